iob_timer_sampler: RTL and testbench

Sequencer that drives the timer's CPU-side port (valid/ready, 2-bit address) on behalf of hardware requesters. On a trigger pulse it issues the STOP, DATA_HIGH, DATA_LOW access sequence, assembles a 64-bit timestamp and pushes it into a small output FIFO. On a clear request it issues a soft-reset write. It sits between event sources (trigger/clear strobes) and one timer instance, so the CPU does not poll the timer for hardware-timestamped events.

---
 rtl/iob_timer_sampler.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_iob_timer_sampler.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_timer_sampler.sv
`default_nettype none
// ============================================================================
// Module   : iob_timer_sampler
// Purpose  : Drives the CPU-side valid/ready port of one timer on behalf of
//            hardware event sources. A trigger strobe runs the
//            STOP -> DATA_HIGH -> DATA_LOW access sequence and pushes the
//            assembled 64-bit timestamp into a small FIFO. A clear strobe
//            issues a soft-reset write to the timer.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1   clock
//   rst        in   1   asynchronous active-high reset
//   trig       in   1   sample request strobe
//   clr        in   1   timer counter clear request strobe
//   tmr_valid  out  1   timer access valid
//   tmr_addr   out  2   timer register (0 RESET, 1 STOP, 2 DATA_HIGH, 3 DATA_LOW)
//   tmr_wdata  out  32  timer write data (1 during the RESET access)
//   tmr_rdata  in   32  timer read data, valid while tmr_valid is high
//   tmr_ready  in   1   timer ready (registered from tmr_valid by the timer)
//   ts_data    out  64  FIFO head timestamp {high, low}
//   ts_valid   out  1   FIFO not empty
//   ts_ready   in   1   consumer pop, effective when ts_valid is high
//   busy       out  1   sequencer not idle
//   ovf        out  1   sticky: a completed sample was dropped (FIFO full)
//   miss       out  1   sticky: a trigger was lost while one was pending
//   flag_clr   in   1   clears ovf and miss
// ============================================================================
module iob_timer_sampler #(
    parameter int FIFO_AW = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trig,
    input  logic        clr,
    output logic        tmr_valid,
    output logic [1:0]  tmr_addr,
    output logic [31:0] tmr_wdata,
    input  logic [31:0] tmr_rdata,
    input  logic        tmr_ready,
    output logic [63:0] ts_data,
    output logic        ts_valid,
    input  logic        ts_ready,
    output logic        busy,
    output logic        ovf,
    output logic        miss,
    input  logic        flag_clr
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int               c_depth   = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] c_ptr_one = {{FIFO_AW{1'b0}}, 1'b1};

    localparam logic [1:0] c_addr_reset = 2'd0;
    localparam logic [1:0] c_addr_stop  = 2'd1;
    localparam logic [1:0] c_addr_high  = 2'd2;
    localparam logic [1:0] c_addr_low   = 2'd3;

    // Sequencer states. Access states alternate with a one-cycle gap state so
    // the timer's registered ready drops before the next access begins.
    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_clr      = 3'd1;
    localparam logic [2:0] c_st_clr_gap  = 3'd2;
    localparam logic [2:0] c_st_stop     = 3'd3;
    localparam logic [2:0] c_st_stop_gap = 3'd4;
    localparam logic [2:0] c_st_rdh      = 3'd5;
    localparam logic [2:0] c_st_rdh_gap  = 3'd6;
    localparam logic [2:0] c_st_rdl      = 3'd7;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic               w_start_clr;
    logic               w_start_trig;
    logic               w_access;
    logic               w_done;

    logic               r_trig_pend;
    logic               r_clr_pend;
    logic               w_miss_set;

    logic [31:0]        r_hi;

    logic [63:0]        r_mem [c_depth];
    logic [FIFO_AW:0]   r_wr_ptr;
    logic [FIFO_AW:0]   r_rd_ptr;
    logic [FIFO_AW:0]   w_rd_ptr_nxt;
    logic [FIFO_AW-1:0] w_wr_idx;
    logic [FIFO_AW-1:0] w_rd_idx_nxt;
    logic               w_empty;
    logic               w_full;
    logic               w_push_req;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic [63:0]        w_push_data;
    logic [63:0]        w_head_nxt;
    logic [63:0]        r_ts_data;

    logic               r_ovf;
    logic               r_miss;

    // ------------------------------------------------------------------------
    // Timer port decode
    // Outputs are decoded straight from the state register so an asynchronous
    // reset removes tmr_valid immediately.
    // ------------------------------------------------------------------------
    always_comb begin
        tmr_valid = 1'b0;
        tmr_addr  = c_addr_reset;
        tmr_wdata = 32'd0;
        case (r_state)
            c_st_clr: begin
                tmr_valid = 1'b1;
                tmr_addr  = c_addr_reset;
                tmr_wdata = 32'd1;
            end
            c_st_stop: begin
                tmr_valid = 1'b1;
                tmr_addr  = c_addr_stop;
            end
            c_st_rdh: begin
                tmr_valid = 1'b1;
                tmr_addr  = c_addr_high;
            end
            c_st_rdl: begin
                tmr_valid = 1'b1;
                tmr_addr  = c_addr_low;
            end
            default: begin
                tmr_valid = 1'b0;
            end
        endcase
    end

    assign w_access = tmr_valid;
    assign w_done   = w_access & tmr_ready;

    // ------------------------------------------------------------------------
    // Next-state logic
    // In IDLE a strobe arriving this edge starts its sequence directly, so no
    // cycle is lost waiting for the pending latch. Clear wins over trigger.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_start_clr  = 1'b0;
        w_start_trig = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (r_clr_pend | clr) begin
                    w_state_nxt = c_st_clr;
                    w_start_clr = 1'b1;
                end else if (r_trig_pend | trig) begin
                    w_state_nxt  = c_st_stop;
                    w_start_trig = 1'b1;
                end
            end
            c_st_clr: begin
                if (w_done) w_state_nxt = c_st_clr_gap;
            end
            c_st_clr_gap: begin
                w_state_nxt = c_st_idle;
            end
            c_st_stop: begin
                if (w_done) w_state_nxt = c_st_stop_gap;
            end
            c_st_stop_gap: begin
                w_state_nxt = c_st_rdh;
            end
            c_st_rdh: begin
                if (w_done) w_state_nxt = c_st_rdh_gap;
            end
            c_st_rdh_gap: begin
                w_state_nxt = c_st_rdl;
            end
            c_st_rdl: begin
                // IDLE itself provides the gap after the last read.
                if (w_done) w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Pending request latches
    // A latch is cleared on the edge its sequence starts; a strobe on that
    // same edge is absorbed by the start. A trigger that finds one already
    // pending and not being consumed is lost and flagged as a miss.
    // ------------------------------------------------------------------------
    assign w_miss_set = trig & r_trig_pend & ~w_start_trig;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trig_pend <= 1'b0;
            r_clr_pend  <= 1'b0;
        end else begin
            r_trig_pend <= w_start_trig ? 1'b0 : (r_trig_pend | trig);
            r_clr_pend  <= w_start_clr  ? 1'b0 : (r_clr_pend  | clr);
        end
    end

    // ------------------------------------------------------------------------
    // High word capture at DATA_HIGH completion
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= 32'd0;
        end else if ((r_state == c_st_rdh) && w_done) begin
            r_hi <= tmr_rdata;
        end
    end

    // ------------------------------------------------------------------------
    // Timestamp FIFO
    // Pointers carry one extra wrap bit to tell full from empty. A push into
    // a full FIFO is still accepted when the consumer pops on the same edge.
    // ------------------------------------------------------------------------
    assign w_wr_idx    = r_wr_ptr[FIFO_AW-1:0];
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                         (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);

    assign w_push_req  = (r_state == c_st_rdl) & w_done;
    assign w_pop       = ~w_empty & ts_ready;
    assign w_push      = w_push_req & (~w_full | w_pop);
    assign w_drop      = w_push_req & ~w_push;
    assign w_push_data = {r_hi, tmr_rdata};

    assign w_rd_ptr_nxt = w_pop ? (r_rd_ptr + c_ptr_one) : r_rd_ptr;
    assign w_rd_idx_nxt = w_rd_ptr_nxt[FIFO_AW-1:0];

    // The head register must see data written this edge when the write lands
    // in the slot that becomes the head (FIFO empty, or emptied by this pop).
    assign w_head_nxt = (w_push && (w_wr_idx == w_rd_idx_nxt)) ? w_push_data
                                                              : r_mem[w_rd_idx_nxt];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= 64'd0;
            end
        end else if (w_push) begin
            r_mem[w_wr_idx] <= w_push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_ts_data <= 64'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            if (w_push || w_pop) begin
                r_ts_data <= w_head_nxt;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sticky status flags; flag_clr beats a same-edge set.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf  <= 1'b0;
            r_miss <= 1'b0;
        end else begin
            if (flag_clr) begin
                r_ovf  <= 1'b0;
                r_miss <= 1'b0;
            end else begin
                if (w_drop)     r_ovf  <= 1'b1;
                if (w_miss_set) r_miss <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ts_data  = r_ts_data;
    assign ts_valid = ~w_empty;
    assign busy     = (r_state != c_st_idle);
    assign ovf      = r_ovf;
    assign miss     = r_miss;

endmodule

`default_nettype wire

// File: tb/tb_iob_timer_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_iob_timer_sampler
// Purpose  : Self-checking bench for iob_timer_sampler with a behavioural
//            timer (registered ready, snapshot on STOP, soft reset on RESET).
// Revision : 1.0 - initial release
// ============================================================================
module tb_iob_timer_sampler;

    localparam int          FIFO_AW = 2;
    localparam int          DEPTH   = 4;
    localparam logic [63:0] C_INIT  = 64'h1234_5678_FFFF_FFF0;

    logic        clk, rst, trig, clr, ts_ready, flag_clr;
    logic        tmr_valid, tmr_ready, ts_valid, busy, ovf, miss;
    logic [1:0]  tmr_addr;
    logic [31:0] tmr_wdata, tmr_rdata;
    logic [63:0] ts_data;

    int n_tests = 0;
    int n_fail  = 0;

    iob_timer_sampler #(.FIFO_AW(FIFO_AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .trig      (trig),
        .clr       (clr),
        .tmr_valid (tmr_valid),
        .tmr_addr  (tmr_addr),
        .tmr_wdata (tmr_wdata),
        .tmr_rdata (tmr_rdata),
        .tmr_ready (tmr_ready),
        .ts_data   (ts_data),
        .ts_valid  (ts_valid),
        .ts_ready  (ts_ready),
        .busy      (busy),
        .ovf       (ovf),
        .miss      (miss),
        .flag_clr  (flag_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Timer model. ecnt counts edges since reset release (0 = first edge).
    // ------------------------------------------------------------------------
    logic [63:0] t_cnt, t_snap;
    logic        t_rdy;
    int unsigned ecnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t_cnt  <= C_INIT;
            t_snap <= 64'd0;
            t_rdy  <= 1'b0;
            ecnt   <= 0;
        end else begin
            t_rdy <= tmr_valid;
            ecnt  <= ecnt + 1;
            if (tmr_valid && t_rdy && tmr_addr == 2'd0 && tmr_wdata[0])
                t_cnt <= 64'd0;
            else
                t_cnt <= t_cnt + 64'd1;
            if (tmr_valid && t_rdy && tmr_addr == 2'd1)
                t_snap <= t_cnt;
        end
    end

    assign tmr_ready = t_rdy;
    assign tmr_rdata = !tmr_valid       ? 32'd0 :
                       tmr_addr == 2'd2 ? t_snap[63:32] :
                       tmr_addr == 2'd3 ? t_snap[31:0]  : 32'd0;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pop_one();
        ts_ready = 1'b1;
        tick();
        ts_ready = 1'b0;
    endtask

    task automatic do_reset(input bit check);
        rst = 1'b1; trig = 1'b0; clr = 1'b0; ts_ready = 1'b0; flag_clr = 1'b0;
        tick();
        tick();
        if (check) begin
            chk("rst tmr", 64'({tmr_valid, tmr_addr, tmr_wdata}), 64'd0);
            chk("rst ts_valid", 64'(ts_valid), 64'd0);
            chk("rst ts_data", ts_data, 64'd0);
            chk("rst flags", 64'({busy, ovf, miss}), 64'd0);
        end
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------------
    typedef struct {
        logic        trig, clr, rdy;
        logic        v;
        logic [1:0]  a;
        logic        w, b, t;
        logic        chk_ts;
        logic [63:0] ts;
    } vec_t;

    vec_t vq[$];

    task automatic addv(input logic tg, input logic cl, input logic rd,
                        input logic v, input logic [1:0] a, input logic w,
                        input logic b, input logic t,
                        input logic ck, input logic [63:0] ts);
        vec_t x;
        x.trig = tg; x.clr = cl; x.rdy = rd; x.v = v; x.a = a; x.w = w;
        x.b = b; x.t = t; x.chk_ts = ck; x.ts = ts;
        vq.push_back(x);
    endtask

    // ------------------------------------------------------------------------
    // Reference model for the random phase: each sequence is a fixed
    // timeline (sample 9 edges, clear 4 edges) and the timer value is linear
    // in time since the last clear.
    // ------------------------------------------------------------------------
    logic [63:0] mq[$];
    bit          m_tp, m_cp, m_ovf, m_miss;
    int          m_free, m_kind, m_start, m_push_edge, m_base_edge;
    logic [63:0] m_base, m_push_val;

    task automatic model_init();
        mq.delete();
        m_tp = 0; m_cp = 0; m_ovf = 0; m_miss = 0;
        m_free = 0; m_kind = 0; m_start = 0; m_push_edge = -1;
        m_base = C_INIT; m_base_edge = 0; m_push_val = 64'd0;
    endtask

    task automatic model_step(input int e);
        bit pop, drop, st_t, st_c, miss_set;
        int pre;
        pre  = mq.size();
        pop  = (pre != 0) && ts_ready;
        drop = 0;
        if (pop) void'(mq.pop_front());
        if (e == m_push_edge) begin
            if (pre < DEPTH || pop) mq.push_back(m_push_val);
            else drop = 1;
            m_push_edge = -1;
        end
        st_t = 0; st_c = 0;
        if (e >= m_free) begin
            if (m_cp || clr) begin
                st_c = 1; m_kind = 2; m_start = e; m_free = e + 4;
                m_base = 64'd0; m_base_edge = e + 3;
            end else if (m_tp || trig) begin
                st_t = 1; m_kind = 1; m_start = e; m_free = e + 9;
                m_push_edge = e + 8;
                m_push_val  = m_base + 64'(longint'(e + 2 - m_base_edge));
            end
        end
        miss_set = trig && m_tp && !st_t;
        m_tp   = st_t ? 1'b0 : (m_tp | trig);
        m_cp   = st_c ? 1'b0 : (m_cp | clr);
        m_miss = flag_clr ? 1'b0 : (m_miss | miss_set);
        m_ovf  = flag_clr ? 1'b0 : (m_ovf | drop);
    endtask

    // Expected {valid, addr, wdata, busy, ts_valid, ovf, miss} after edge e.
    function automatic logic [38:0] model_ctl(input int e);
        int         d;
        logic       v, w;
        logic [1:0] a;
        d = e - m_start; v = 0; w = 0; a = 2'd0;
        if (m_kind == 1 && d >= 0 && d < 8) begin
            v = !(d == 2 || d == 5);
            if (v) a = (d < 2) ? 2'd1 : (d < 5) ? 2'd2 : 2'd3;
        end else if (m_kind == 2 && d >= 0 && d < 3) begin
            v = (d < 2); w = (d < 2);
        end
        return {v, a, 31'd0, w, (e < m_free - 1), (mq.size() != 0), m_ovf, m_miss};
    endfunction

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    logic [63:0] exp_q[$];
    logic [63:0] e_ts;
    int unsigned k;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Table: single trigger, drain, then clear+trigger on one edge.
        addv(1,0,0, 1,2'd1,0,1,0, 0,64'd0);
        addv(0,0,0, 1,2'd1,0,1,0, 0,64'd0);
        addv(0,0,0, 0,2'd0,0,1,0, 0,64'd0);
        addv(0,0,0, 1,2'd2,0,1,0, 0,64'd0);
        addv(0,0,0, 1,2'd2,0,1,0, 0,64'd0);
        addv(0,0,0, 0,2'd0,0,1,0, 0,64'd0);
        addv(0,0,0, 1,2'd3,0,1,0, 0,64'd0);
        addv(0,0,0, 1,2'd3,0,1,0, 0,64'd0);
        addv(0,0,0, 0,2'd0,0,0,1, 1,C_INIT + 64'd2);
        addv(0,0,0, 0,2'd0,0,0,1, 1,C_INIT + 64'd2);
        addv(0,0,1, 0,2'd0,0,0,0, 0,64'd0);
        addv(1,1,0, 1,2'd0,1,1,0, 0,64'd0);
        addv(0,0,0, 1,2'd0,1,1,0, 0,64'd0);
        addv(0,0,0, 0,2'd0,0,1,0, 0,64'd0);
        addv(0,0,0, 0,2'd0,0,0,0, 0,64'd0);
        addv(0,0,0, 1,2'd1,0,1,0, 0,64'd0);
        addv(0,0,0, 1,2'd1,0,1,0, 0,64'd0);
        addv(0,0,0, 0,2'd0,0,1,0, 0,64'd0);
        addv(0,0,0, 1,2'd2,0,1,0, 0,64'd0);
        addv(0,0,0, 1,2'd2,0,1,0, 0,64'd0);
        addv(0,0,0, 0,2'd0,0,1,0, 0,64'd0);
        addv(0,0,0, 1,2'd3,0,1,0, 0,64'd0);
        addv(0,0,0, 1,2'd3,0,1,0, 0,64'd0);
        addv(0,0,0, 0,2'd0,0,0,1, 1,64'd3);
        addv(0,0,1, 0,2'd0,0,0,0, 0,64'd0);

        do_reset(1);
        foreach (vq[i]) begin
            trig = vq[i].trig; clr = vq[i].clr; ts_ready = vq[i].rdy;
            tick();
            chk($sformatf("vec%0d ctl", i),
                64'({tmr_valid, tmr_addr, tmr_wdata, busy, ts_valid}),
                64'({vq[i].v, vq[i].a, 31'd0, vq[i].w, vq[i].b, vq[i].t}));
            if (vq[i].chk_ts) chk($sformatf("vec%0d ts", i), ts_data, vq[i].ts);
        end
        trig = 0; clr = 0; ts_ready = 0;

        // Three back-to-back triggers: one sampled, one pending, one missed.
        do_reset(0);
        trig = 1'b1;
        tick(); tick(); tick();
        trig = 1'b0;
        chk("h1 miss set", 64'(miss), 64'd1);
        repeat (20) tick();
        chk("h1 first", ts_data, C_INIT + 64'd2);
        pop_one();
        chk("h1 second valid", 64'(ts_valid), 64'd1);
        chk("h1 second", ts_data, C_INIT + 64'd11);
        pop_one();
        chk("h1 only two", 64'(ts_valid), 64'd0);
        flag_clr = 1'b1; tick(); flag_clr = 1'b0;
        chk("h1 miss cleared", 64'(miss), 64'd0);

        // Overflow: five samples into a four-entry FIFO.
        do_reset(0);
        exp_q.delete();
        for (int j = 0; j < 5; j++) begin
            exp_q.push_back(C_INIT + 64'(ecnt) + 64'd2);
            trig = 1'b1; tick(); trig = 1'b0;
            repeat (11) tick();
        end
        chk("h2 ovf", 64'(ovf), 64'd1);
        chk("h2 head", ts_data, exp_q[0]);
        flag_clr = 1'b1; tick(); flag_clr = 1'b0;
        chk("h2 ovf cleared", 64'(ovf), 64'd0);
        k = ecnt;
        trig = 1'b1; tick(); trig = 1'b0;
        repeat (7) tick();
        ts_ready = 1'b1; tick(); ts_ready = 1'b0;
        chk("h2 full push+pop ovf", 64'(ovf), 64'd0);
        exp_q[4] = C_INIT + 64'(k) + 64'd2;
        for (int j = 1; j < 5; j++) begin
            chk($sformatf("h2 pop%0d", j), ts_data, exp_q[j]);
            pop_one();
        end
        chk("h2 drained", 64'(ts_valid), 64'd0);

        // Clear arriving during DATA_HIGH is deferred behind the sample.
        k = ecnt;
        e_ts = C_INIT + 64'(k) + 64'd2;
        trig = 1'b1; tick(); trig = 1'b0;
        repeat (3) tick();
        clr = 1'b1; tick(); clr = 1'b0;
        repeat (4) tick();
        chk("h3 sample", ts_data, e_ts);
        chk("h3 idle gap", 64'({tmr_valid, busy}), 64'd0);
        tick();
        chk("h3 clr access", 64'({tmr_valid, tmr_addr, tmr_wdata}), 64'({1'b1, 2'd0, 32'd1}));
        repeat (3) tick();
        chk("h3 retained", 64'({busy, ts_valid}), 64'({1'b0, 1'b1}));
        chk("h3 retained ts", ts_data, e_ts);

        // Reset in DATA_LOW with a non-empty FIFO and miss set.
        trig = 1'b1; tick(); tick(); tick(); trig = 1'b0;
        chk("h4 miss pre", 64'(miss), 64'd1);
        repeat (4) tick();
        chk("h4 in rdl", 64'({tmr_valid, tmr_addr}), 64'({1'b1, 2'd3}));
        #2 rst = 1'b1;
        #1;
        chk("h4 async valid", 64'(tmr_valid), 64'd0);
        chk("h4 async state", 64'({ts_valid, busy, ovf, miss}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        trig = 1'b1; tick(); trig = 1'b0;
        repeat (8) tick();
        chk("h4 after release", 64'(ts_valid), 64'd1);
        chk("h4 after release ts", ts_data, C_INIT + 64'd2);

        // Random traffic against the timeline model.
        do_reset(0);
        model_init();
        for (int e = 0; e < 3000; e++) begin
            trig     = ($urandom_range(0, 5) == 0);
            clr      = ($urandom_range(0, 39) == 0);
            flag_clr = ($urandom_range(0, 49) == 0);
            ts_ready = (e < 1500) ? ($urandom_range(0, 15) == 0) : 1'($urandom_range(0, 1));
            model_step(e);
            tick();
            chk($sformatf("rnd%0d ctl", e),
                64'({tmr_valid, tmr_addr, tmr_wdata, busy, ts_valid, ovf, miss}),
                64'(model_ctl(e)));
            if (mq.size() != 0) chk($sformatf("rnd%0d ts", e), ts_data, mq[0]);
        end
        trig = 0; clr = 0; flag_clr = 0; ts_ready = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
